data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arb_pkg.sv | 15 +
 rtl/data_mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default sizing for the two-master data memory arbiter.
package data_mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH     = 10;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TRANSFER_WIDTH = 4;
  localparam int DEF_MAX_BURST      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of a single-port data memory with a registered read port.
// Master 0 (core LSU) has priority from idle; bursts are capped only while the other master waits.
//
// state | meaning
// IDLE  | no previous owner, master 0 wins a tie
// OWN0  | master 0 holds the bus
// OWN1  | master 1 holds the bus
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TRANSFER_WIDTH = DEF_TRANSFER_WIDTH,
  parameter int MAX_BURST      = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  input  logic [TRANSFER_WIDTH-1:0] m0_be,
  output logic                      m0_gnt,
  output logic                      m0_rvalid,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  input  logic [TRANSFER_WIDTH-1:0] m1_be,
  output logic                      m1_gnt,
  output logic                      m1_rvalid,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data_in,
  output logic [TRANSFER_WIDTH-1:0] mem_write_transfer,
  input  logic [DATA_WIDTH-1:0]     mem_data_out
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state;
  logic [CNT_W-1:0] burst_cnt;
  logic             rd_valid;
  logic             rd_tag;
  logic             gnt0;
  logic             gnt1;
  logic [CNT_W-1:0] burst_inc;

  // The owner keeps the bus under the cap, or beyond it when nobody else is waiting.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case (state)
        OWN0: begin
          if (m0_req && ((burst_cnt < BURST_MAX) || !m1_req)) gnt0 = 1'b1;
          else if (m1_req)                                   gnt1 = 1'b1;
        end
        OWN1: begin
          if (m1_req && ((burst_cnt < BURST_MAX) || !m0_req)) gnt1 = 1'b1;
          else if (m0_req)                                   gnt0 = 1'b1;
        end
        default: begin
          if (m0_req)      gnt0 = 1'b1;
          else if (m1_req) gnt1 = 1'b1;
        end
      endcase
    end
  end

  assign burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rd_valid  <= 1'b0;
      rd_tag    <= 1'b0;
    end else begin
      rd_valid <= (gnt0 && !m0_we) || (gnt1 && !m1_we);
      rd_tag   <= gnt1;
      if (gnt0) begin
        state     <= OWN0;
        burst_cnt <= (state == OWN0) ? burst_inc : CNT_W'(1);
      end else if (gnt1) begin
        state     <= OWN1;
        burst_cnt <= (state == OWN1) ? burst_inc : CNT_W'(1);
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    mem_we             = 1'b0;
    mem_addr           = '0;
    mem_data_in        = '0;
    mem_write_transfer = '0;
    if (gnt0) begin
      mem_we             = m0_we;
      mem_addr           = m0_addr;
      mem_data_in        = m0_wdata;
      mem_write_transfer = m0_be;
    end else if (gnt1) begin
      mem_we             = m1_we;
      mem_addr           = m1_addr;
      mem_data_in        = m1_wdata;
      mem_write_transfer = m1_be;
    end
  end

  // Gating with rst drops a return already in flight the moment reset rises.
  assign m0_rvalid = rd_valid && !rd_tag && !rst;
  assign m1_rvalid = rd_valid &&  rd_tag && !rst;
  assign m0_rdata  = m0_rvalid ? mem_data_out : '0;
  assign m1_rdata  = m1_rvalid ? mem_data_out : '0;

endmodule
